coproc_instr_scheduler: RTL and testbench

- Arbitrates two instruction requesters (host port 0, DMA/loader port 1) onto the single instruction input of the crypto coprocessor controller.
- Issues one 267-bit instruction at a time and, for read-type instructions, waits for the controller's done and returns the 256-bit result to the requester with an ID tag.
- Includes a bounded completion timeout.
- Sits directly between the bus/DMA front end and the controller.

---
 rtl/coproc_instr_scheduler.sv | 142 ++++++++++++++
 tb/tb_coproc_instr_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_instr_scheduler.sv
// rtl/coproc_instr_scheduler.sv - two-port round-robin instruction scheduler for the crypto coprocessor controller
//
// Ports:
//   clock, reset_n            : system clock, asynchronous active-low reset
//   req0_* / req1_*           : requester valid/instr inputs, combinational ready outputs
//   ctrl_valid, ctrl_instr    : one-cycle issue strobe and held instruction word to the controller
//   ctrl_done, ctrl_out       : controller result pulse and result data
//   resp_valid/id/err/data    : response to the requester, held until resp_ready
//   busy                      : high whenever the scheduler is not idle
module coproc_instr_scheduler #(
    parameter int IW      = 267,
    parameter int DW      = 256,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic [IW-1:0] req0_instr,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [IW-1:0] req1_instr,
    output logic          req1_ready,
    output logic          ctrl_valid,
    output logic [IW-1:0] ctrl_instr,
    input  logic          ctrl_done,
    input  logic [DW-1:0] ctrl_out,
    output logic          resp_valid,
    output logic          resp_id,
    output logic          resp_err,
    output logic [DW-1:0] resp_data,
    input  logic          resp_ready,
    output logic          busy
);

    localparam int WR_BIT = 260;
    localparam int TW     = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_grant;
    logic            r_ctrl_valid;
    logic [IW-1:0]   r_ctrl_instr;
    logic            r_id;
    logic [TW-1:0]   r_timer;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic [DW-1:0]   r_resp_data;

    logic            w_idle;
    logic            w_grant0;
    logic            w_grant1;

    // Round-robin: on a tie the port that did not win last time is granted.
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

    // Ready is gated by reset_n so every output reads 0 while reset is held.
    assign req0_ready = reset_n && w_idle && w_grant0;
    assign req1_ready = reset_n && w_idle && w_grant1;

    assign ctrl_valid = r_ctrl_valid;
    assign ctrl_instr = r_ctrl_instr;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_id;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_resp_data;
    assign busy       = !w_idle;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_ctrl_valid <= 1'b0;
            r_ctrl_instr <= '0;
            r_id         <= 1'b0;
            r_timer      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0) begin
                        r_ctrl_instr <= req0_instr;
                        r_id         <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_ctrl_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end else if (w_grant1) begin
                        r_ctrl_instr <= req1_instr;
                        r_id         <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_ctrl_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ctrl_valid <= 1'b0;
                    if (r_ctrl_instr[WR_BIT]) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still delivers real data.
                    if (ctrl_done) begin
                        r_resp_data  <= ctrl_out;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_instr_scheduler.sv
// tb/tb_coproc_instr_scheduler.sv - self-checking bench for coproc_instr_scheduler
module tb_coproc_instr_scheduler;

    localparam int IW      = 267;
    localparam int DW      = 256;
    localparam int TIMEOUT = 64;

    logic          clock;
    logic          reset_n;
    logic          req0_valid;
    logic [IW-1:0] req0_instr;
    logic          req0_ready;
    logic          req1_valid;
    logic [IW-1:0] req1_instr;
    logic          req1_ready;
    logic          ctrl_valid;
    logic [IW-1:0] ctrl_instr;
    logic          ctrl_done;
    logic [DW-1:0] ctrl_out;
    logic          resp_valid;
    logic          resp_id;
    logic          resp_err;
    logic [DW-1:0] resp_data;
    logic          resp_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;
    bit model_last_grant;

    coproc_instr_scheduler #(.IW(IW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
        .ctrl_valid(ctrl_valid), .ctrl_instr(ctrl_instr),
        .ctrl_done(ctrl_done), .ctrl_out(ctrl_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
        .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [IW-1:0] mk(input logic wr, input logic [3:0] op, input logic [255:0] d);
        return {6'b0, wr, op, d};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Round-robin rule: lone requester wins; a tie goes to the port not granted last.
    function automatic int pick(input bit v0, input bit v1, input bit lg);
        if (v0 && v1) return lg ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_instr = '0;   req1_instr = '0;
        ctrl_done = 1'b0;  ctrl_out = '0;  resp_ready = 1'b0;
        step(); step();
        reset_n = 1'b1;
        model_last_grant = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_instr = mk(1'b1, 4'd3, 256'd7);
        #1;
        checks++;
        if ({ctrl_valid, resp_valid, resp_id, resp_err, busy, req0_ready, req1_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {ctrl_valid, resp_valid, resp_id, resp_err, busy, req0_ready, req1_ready});
        end
        checks++;
        if (ctrl_instr !== '0 || resp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got instr=%0h data=%0h expected 0", ctrl_instr, resp_data);
        end
        step();
        req0_valid = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_single_write();
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(1'b1, 4'd8, 256'd12);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %b expected 1", req0_ready); end
        step();
        req0_valid = 1'b0; req0_instr = '0;
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_instr[260:256] !== 5'b1_1000 || ctrl_instr[255:0] !== 256'd12) begin
            errors++;
            $display("FAIL write_issue: got v=%b op=%b d=%0h expected v=1 op=11000 d=c",
                     ctrl_valid, ctrl_instr[260:256], ctrl_instr[255:0]);
        end
        step();
        checks++;
        if (ctrl_valid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_after: got cv=%b rv=%b busy=%b expected 0 0 0", ctrl_valid, resp_valid, busy);
        end
        req0_valid = 1'b1; req0_instr = mk(1'b1, 4'd8, 256'd13);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL write_ready_again: got %b expected 1", req0_ready); end
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL write_no_resp: got %b expected 0", resp_valid); end
        end
    endtask

    task automatic test_read_roundtrip();
        logic [IW-1:0] ins;
        ins = mk(1'b0, 4'd9, rnd256());
        do_reset();
        req1_valid = 1'b1; req1_instr = ins;
        step();
        req1_valid = 1'b0; req1_instr = '0;
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_instr !== ins) begin
            errors++;
            $display("FAIL read_issue: got v=%b instr=%0h expected v=1 instr=%0h", ctrl_valid, ctrl_instr, ins);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL read_early_resp: got %b expected 0", resp_valid); end
        end
        ctrl_done = 1'b1; ctrl_out = 256'h4;
        step();
        ctrl_done = 1'b0; ctrl_out = '1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_err !== 1'b0 || resp_data !== 256'h4) begin
                errors++;
                $display("FAIL read_resp[%0d]: got v=%b id=%b err=%b d=%0h expected 1 1 0 4",
                         i, resp_valid, resp_id, resp_err, resp_data);
            end
            if (i < 4) step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_release: got v=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_arbitration();
        int exp_port;
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(1'b1, 4'd8, 256'd0);
        req1_valid = 1'b1; req1_instr = mk(1'b1, 4'd10, 256'b0100);
        for (int g = 0; g < 4; g++) begin
            exp_port = pick(1'b1, 1'b1, model_last_grant);
            #1;
            checks++;
            if (req0_ready !== (exp_port == 0) || req1_ready !== (exp_port == 1)) begin
                errors++;
                $display("FAIL arb_grant[%0d]: got r0=%b r1=%b expected port %0d", g, req0_ready, req1_ready, exp_port);
            end
            model_last_grant = exp_port[0];
            step();
            checks++;
            if (ctrl_valid !== 1'b1 || ctrl_instr[259:256] !== ((exp_port == 0) ? 4'd8 : 4'd10)) begin
                errors++;
                $display("FAIL arb_op[%0d]: got v=%b op=%0d expected op %0d", g, ctrl_valid,
                         ctrl_instr[259:256], (exp_port == 0) ? 8 : 10);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        logic [DW-1:0] v;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            req0_valid = 1'b1; req0_instr = mk(1'b0, 4'd2, rnd256());
            step();
            req0_valid = 1'b0;
            ctrl_out = rnd256();
            step();
            if (run == 0) begin
                n = 0;
                while (n < TIMEOUT + 8 && resp_valid !== 1'b1) begin step(); n++; end
                checks++;
                if (n != TIMEOUT) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT); end
                checks++;
                if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== '0 || resp_id !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_resp: got v=%b err=%b d=%0h id=%b expected 1 1 0 0",
                             resp_valid, resp_err, resp_data, resp_id);
                end
            end else begin
                for (int i = 0; i < TIMEOUT - 1; i++) step();
                checks++;
                if (resp_valid !== 1'b0) begin errors++; $display("FAIL coincide_early: got %b expected 0", resp_valid); end
                v = rnd256();
                ctrl_done = 1'b1; ctrl_out = v;
                step();
                ctrl_done = 1'b0;
                checks++;
                if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== v) begin
                    errors++;
                    $display("FAIL coincide_resp: got v=%b err=%b d=%0h expected 1 0 %0h", resp_valid, resp_err, resp_data, v);
                end
            end
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req0_valid = 1'b1; req0_instr = mk(1'b0, 4'd5, rnd256());
        step();
        req0_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ctrl_valid, resp_valid, resp_err, busy} !== 4'b0 || ctrl_instr !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got cv=%b rv=%b err=%b busy=%b instr=%0h expected all 0",
                     ctrl_valid, resp_valid, resp_err, busy, ctrl_instr);
        end
        step();
        reset_n = 1'b1;
        model_last_grant = 1'b1;
        step();
        ctrl_done = 1'b1; ctrl_out = rnd256();
        step();
        ctrl_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stray: got rv=%b busy=%b expected 0 0", resp_valid, busy);
            end
            step();
        end
        req0_valid = 1'b1; req0_instr = mk(1'b1, 4'd1, 256'd1);
        req1_valid = 1'b1; req1_instr = mk(1'b1, 4'd2, 256'd2);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tie: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_instr !== mk(1'b1, 4'd1, 256'd1)) begin
            errors++;
            $display("FAIL midreset_issue: got v=%b instr=%0h expected port0 write", ctrl_valid, ctrl_instr);
        end
        step();
    endtask

    task automatic test_stray_done();
        logic [DW-1:0] v;
        do_reset();
        ctrl_done = 1'b1; ctrl_out = rnd256();
        step();
        ctrl_done = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: got rv=%b busy=%b expected 0 0", resp_valid, busy);
        end
        req1_valid = 1'b1; req1_instr = mk(1'b0, 4'd6, rnd256());
        step();
        req1_valid = 1'b0;
        ctrl_done = 1'b1; ctrl_out = rnd256();
        step();
        ctrl_done = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_issue: got rv=%b busy=%b expected 0 1", resp_valid, busy);
        end
        v = rnd256();
        ctrl_done = 1'b1; ctrl_out = v;
        step();
        ctrl_done = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== v || resp_id !== 1'b1 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_final: got v=%b d=%0h id=%b err=%b expected 1 %0h 1 0",
                     resp_valid, resp_data, resp_id, resp_err, v);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_random();
        bit v0, v1, wr;
        int port, d, n, exp_n, stall;
        bit exp_err;
        logic [IW-1:0] i0, i1, exp_instr;
        logic [DW-1:0] val, exp_data;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            v0 = $urandom_range(0, 1);
            v1 = $urandom_range(0, 1);
            if (!v0 && !v1) v0 = 1'b1;
            i0 = mk($urandom_range(0, 1), 4'($urandom), rnd256());
            i1 = mk($urandom_range(0, 1), 4'($urandom), rnd256());
            req0_valid = v0; req0_instr = i0;
            req1_valid = v1; req1_instr = i1;
            port = pick(v0, v1, model_last_grant);
            exp_instr = (port == 0) ? i0 : i1;
            wr = exp_instr[260];
            #1;
            checks++;
            if (req0_ready !== (port == 0) || req1_ready !== (port == 1)) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: got r0=%b r1=%b expected port %0d", t, req0_ready, req1_ready, port);
            end
            model_last_grant = port[0];
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_instr = mk(1'b0, 4'd0, rnd256()); req1_instr = mk(1'b1, 4'd15, rnd256());
            checks++;
            if (ctrl_valid !== 1'b1 || ctrl_instr !== exp_instr) begin
                errors++;
                $display("FAIL rnd_issue[%0d]: got v=%b instr=%0h expected %0h", t, ctrl_valid, ctrl_instr, exp_instr);
            end
            step();
            if (wr) begin
                checks++;
                if (ctrl_valid !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_write_done[%0d]: got cv=%b busy=%b rv=%b expected 0 0 0", t, ctrl_valid, busy, resp_valid);
                end
            end else begin
                d = $urandom_range(0, TIMEOUT + 4);
                val = rnd256();
                exp_err = (d >= TIMEOUT);
                exp_n = exp_err ? TIMEOUT : d + 1;
                exp_data = exp_err ? '0 : val;
                n = 0;
                while (n < TIMEOUT + 10 && resp_valid !== 1'b1) begin
                    ctrl_done = (n == d); ctrl_out = val;
                    step();
                    ctrl_done = 1'b0; ctrl_out = rnd256();
                    n++;
                end
                checks++;
                if (n != exp_n) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, n, exp_n); end
                stall = $urandom_range(0, 3);
                for (int s = 0; s <= stall; s++) begin
                    checks++;
                    if (resp_valid !== 1'b1 || resp_id !== port[0] || resp_err !== exp_err || resp_data !== exp_data) begin
                        errors++;
                        $display("FAIL rnd_resp[%0d]: got v=%b id=%b err=%b d=%0h expected 1 %0d %b %0h",
                                 t, resp_valid, resp_id, resp_err, resp_data, port, exp_err, exp_data);
                    end
                    if (s < stall) step();
                end
                resp_ready = 1'b1;
                step();
                resp_ready = 1'b0;
                checks++;
                if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_release[%0d]: got rv=%b busy=%b expected 0 0", t, resp_valid, busy);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_instr = '0;   req1_instr = '0;
        ctrl_done = 1'b0;  ctrl_out = '0;  resp_ready = 1'b0;
        model_last_grant = 1'b1;
        test_reset();
        test_single_write();
        test_read_roundtrip();
        test_arbitration();
        test_timeout();
        test_reset_mid_wait();
        test_stray_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
